// File: rtl/pipe_shifter_pkg.sv
// Shared types and stage-partitioning helpers for the pipelined funnel shifter.
package pipe_shifter_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101
  } shift_op_e;

  // Remainder levels go one each to the earliest stages.
  function automatic int levels_in_stage(input int stage, input int total_levels, input int stages);
    int n;
    n = total_levels / stages;
    if (stage < (total_levels % stages)) begin
      n = n + 32'sd1;
    end else begin
      n = n;
    end
    return n;
  endfunction

  function automatic int first_level(input int stage, input int total_levels, input int stages);
    int f;
    f = 32'sd0;
    for (int i = 32'sd0; i < stage; i++) begin
      f = f + levels_in_stage(i, total_levels, stages);
    end
    return f;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the funnel shifter: a slice of the mux ladder, the
// valid/ready bookkeeping and the payload register. The last stage also applies the output window.
module shift_stage
  import pipe_shifter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 5,
  parameter int FIRST_LEVEL = 0,
  parameter int NUM_LEVELS  = 1,
  parameter bit IS_LAST     = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [2*XLEN-1:0]         in_fun,
  input  logic [$clog2(XLEN)-1:0]   in_k,
  input  logic                      in_left,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [2*XLEN-1:0]         out_fun,
  output logic [$clog2(XLEN)-1:0]   out_k,
  output logic                      out_left,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int SW = $clog2(XLEN);

  logic [2*XLEN-1:0] lvl_s;
  logic [2*XLEN-1:0] nxt_fun_s;
  logic [2*XLEN-1:0] fun_r;
  logic [SW-1:0]     k_r;
  logic              left_r;
  logic [TAG_W-1:0]  tag_r;
  logic              valid_r;
  logic              ready_s;
  logic              load_s;

  assign ready_s = !valid_r || out_ready;
  assign load_s  = in_valid && ready_s;

  // Mux levels for this stage (global level g selects on k bit SW-1-g), then the output window.
  always_comb begin
    lvl_s = in_fun;
    for (int g = FIRST_LEVEL; g < FIRST_LEVEL + NUM_LEVELS; g++) begin
      if (in_k[SW-1-g]) begin
        lvl_s = lvl_s >> (32'd1 << (SW - 1 - g));
      end else begin
        lvl_s = lvl_s;
      end
    end
    if (IS_LAST) begin
      if (in_left) begin
        nxt_fun_s = {{XLEN{1'b0}}, lvl_s[XLEN:1]};
      end else begin
        nxt_fun_s = {{XLEN{1'b0}}, lvl_s[XLEN-1:0]};
      end
    end else begin
      nxt_fun_s = lvl_s;
    end
  end

  // Payload register: load on upstream transfer, drop valid once the content leaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      fun_r   <= '0;
      k_r     <= '0;
      left_r  <= 1'b0;
      tag_r   <= '0;
    end else if (load_s) begin
      valid_r <= 1'b1;
      fun_r   <= nxt_fun_s;
      k_r     <= in_k;
      left_r  <= in_left;
      tag_r   <= in_tag;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign out_valid = valid_r;
  assign out_fun   = fun_r;
  assign out_k     = k_r;
  assign out_left  = left_r;
  assign out_tag   = tag_r;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined funnel shifter (SLL/SRL/SRA, plus ROL/ROR when PIPE_SHIFTER_ROTATE_EN
// is defined) with a valid/ready handshake and a pass-through tag.
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_a,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [2:0]              in_op,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_y,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int SW = $clog2(XLEN);

  shift_op_e         op_s;
  logic [2*XLEN-1:0] fun0_s;
  logic [SW-1:0]     k0_s;
  logic              left0_s;

  logic              valid_s [PIPE_STAGES+1];
  logic              ready_s [PIPE_STAGES+1];
  logic [2*XLEN-1:0] fun_s   [PIPE_STAGES+1];
  logic [SW-1:0]     k_s     [PIPE_STAGES+1];
  logic              left_s  [PIPE_STAGES+1];
  logic [TAG_W-1:0]  tag_s   [PIPE_STAGES+1];
  logic              unused_s;

  // Op decode; without rotate support bit 2 is don't-care.
  always_comb begin
    case (in_op)
      3'b000, 3'b010: op_s = OP_SLL;
      3'b001:         op_s = OP_SRL;
      3'b011:         op_s = OP_SRA;
`ifdef PIPE_SHIFTER_ROTATE_EN
      3'b100, 3'b110: op_s = OP_ROL;
      3'b101, 3'b111: op_s = OP_ROR;
`else
      3'b100, 3'b110: op_s = OP_SLL;
      3'b101:         op_s = OP_SRL;
      3'b111:         op_s = OP_SRA;
`endif
      default:        op_s = OP_SLL;
    endcase
  end

  // Funnel {hi, lo} and right-shift amount; left ops shift right by ~s and take window [XLEN:1].
  always_comb begin
    case (op_s)
      OP_SLL:  fun0_s = {in_a, {XLEN{1'b0}}};
      OP_SRL:  fun0_s = {{XLEN{1'b0}}, in_a};
      OP_SRA:  fun0_s = {{XLEN{in_a[XLEN-1]}}, in_a};
`ifdef PIPE_SHIFTER_ROTATE_EN
      OP_ROL:  fun0_s = {in_a, in_a};
      OP_ROR:  fun0_s = {in_a, in_a};
`endif
      default: fun0_s = {in_a, {XLEN{1'b0}}};
    endcase
    left0_s = (op_s == OP_SLL) || (op_s == OP_ROL);
    if (left0_s) begin
      k0_s = ~in_shamt;
    end else begin
      k0_s = in_shamt;
    end
  end

  assign valid_s[0] = in_valid && !reset;
  assign fun_s[0]   = fun0_s;
  assign k_s[0]     = k0_s;
  assign left_s[0]  = left0_s;
  assign tag_s[0]   = in_tag;

  // Combinational ready chain from the consumer back to the input.
  always_comb begin
    ready_s[PIPE_STAGES] = out_ready;
    for (int i = PIPE_STAGES - 1; i >= 0; i--) begin
      ready_s[i] = !valid_s[i+1] || ready_s[i+1];
    end
  end

  assign in_ready = ready_s[0] && !reset;

  for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
    shift_stage #(
      .XLEN        (XLEN),
      .TAG_W       (TAG_W),
      .FIRST_LEVEL (first_level(i, SW, PIPE_STAGES)),
      .NUM_LEVELS  (levels_in_stage(i, SW, PIPE_STAGES)),
      .IS_LAST     (i == PIPE_STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (valid_s[i]),
      .in_fun    (fun_s[i]),
      .in_k      (k_s[i]),
      .in_left   (left_s[i]),
      .in_tag    (tag_s[i]),
      .out_ready (ready_s[i+1]),
      .out_valid (valid_s[i+1]),
      .out_fun   (fun_s[i+1]),
      .out_k     (k_s[i+1]),
      .out_left  (left_s[i+1]),
      .out_tag   (tag_s[i+1])
    );
  end

  assign out_valid = valid_s[PIPE_STAGES];
  assign out_y     = fun_s[PIPE_STAGES][XLEN-1:0];
  assign out_tag   = tag_s[PIPE_STAGES];

  assign unused_s = ^{fun_s[PIPE_STAGES][2*XLEN-1:XLEN], k_s[PIPE_STAGES], left_s[PIPE_STAGES]};

endmodule
